acc_cpu_core: RTL and testbench

Parametrised multicycle accumulator processor core, the next generation of the board's fixed 18-bit MAR/MDR/PC/IR/AC/ALU datapath. It generalises data and address widths, replaces the fixed-latency memory with a req/ready handshake that tolerates wait states, and replaces direct LCD writes with a valid/ready output stream. A clock enable replaces the divided slow clock for single-stepping on the board. It sits between the top-level board wrapper and the memory and LCD driver blocks.

---
 rtl/acc_cpu_pkg.sv | 44 ++++
 rtl/acc_cpu_if.sv | 29 ++
 rtl/acc_cpu_alu.sv | 35 +++
 rtl/acc_cpu_core.sv | 208 ++++++++++++++++++++
 tb/tb_acc_cpu_core.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/acc_cpu_pkg.sv
// Shared types for the accumulator core: opcodes, SYS sub-codes, FSM states
// and the ALU operation encoding.
package acc_cpu_pkg;

  typedef enum logic [2:0] {
    OP_LD  = 3'd0,
    OP_ST  = 3'd1,
    OP_ADD = 3'd2,
    OP_SUB = 3'd3,
    OP_AND = 3'd4,
    OP_JMP = 3'd5,
    OP_JZ  = 3'd6,
    OP_SYS = 3'd7
  } opcode_e;

  localparam logic SYS_OUT  = 1'b0;
  localparam logic SYS_HALT = 1'b1;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_READ,
    S_WRITE,
    S_OUT,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    ALU_PASS,
    ALU_ADD,
    ALU_SUB,
    ALU_AND
  } alu_op_e;

  function automatic alu_op_e alu_op_of(input opcode_e op);
    case (op)
      OP_ADD:  return ALU_ADD;
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      default: return ALU_PASS;
    endcase
  endfunction

endpackage

// File: rtl/acc_cpu_if.sv
// Memory req/ready bus and output valid/ready stream of the accumulator core.
interface acc_cpu_if #(
  parameter int DATA_W = 18,
  parameter int ADDR_W = 13
) ();
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ready;
  logic [DATA_W-1:0] mem_rdata;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;

  modport master (
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_ready, mem_rdata,
    output out_valid, out_data,
    input  out_ready
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_ready, mem_rdata,
    input  out_valid, out_data,
    output out_ready
  );
endinterface

// File: rtl/acc_cpu_alu.sv
// Combinational ALU: pass-through of the memory operand, ADD, SUB, AND,
// with result-zero and signed-overflow flags.
module acc_cpu_alu
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W = 18
) (
  input  alu_op_e           op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] y,
  output logic              zero,
  output logic              ovf
);

  always_comb begin
    y   = b;
    ovf = 1'b0;
    case (op)
      ALU_ADD: begin
        y   = a + b;
        ovf = (a[DATA_W-1] == b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_SUB: begin
        y   = a - b;
        ovf = (a[DATA_W-1] != b[DATA_W-1]) && (y[DATA_W-1] != a[DATA_W-1]);
      end
      ALU_AND: y = a & b;
      default: y = b;
    endcase
  end

  assign zero = (y == '0);

endmodule

// File: rtl/acc_cpu_core.sv
// Multicycle accumulator core with req/ready memory, valid/ready output stream
// and clock enable. Define ACC_CPU_OVF_TRAP_EN to halt with trap on ADD/SUB overflow.
module acc_cpu_core
  import acc_cpu_pkg::*;
#(
  parameter int                DATA_W   = 18,
  parameter int                ADDR_W   = 13,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ce,
  acc_cpu_if.master         bus,
  output logic              halted,
  output logic              trap,
  output logic [ADDR_W-1:0] pc_dbg
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] ac_q, ac_d, ir_q, ir_d, mem_wdata_q, mem_wdata_d, out_data_q, out_data_d;
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic              out_valid_q, out_valid_d, halted_q, halted_d;
  logic              fetch_next;

  opcode_e           opcode;
  logic [ADDR_W-1:0] operand;
  alu_op_e           alu_op;
  logic [DATA_W-1:0] alu_b, alu_y;
  logic              alu_zero, alu_ovf;

  assign opcode  = opcode_e'(ir_q[DATA_W-1 -: 3]);
  assign operand = ir_q[ADDR_W-1:0];

  // Outside READ the ALU passes AC through, so its zero flag serves JZ.
  assign alu_op = (state_q == S_READ) ? alu_op_of(opcode) : ALU_PASS;
  assign alu_b  = (state_q == S_READ) ? bus.mem_rdata : ac_q;

  acc_cpu_alu #(.DATA_W(DATA_W)) u_alu (
    .op   (alu_op),
    .a    (ac_q),
    .b    (alu_b),
    .y    (alu_y),
    .zero (alu_zero),
    .ovf  (alu_ovf)
  );

  if (DATA_W > ADDR_W + 3) begin : g_ir_pad
    logic unused_ir_pad;
    assign unused_ir_pad = ^ir_q[DATA_W-4:ADDR_W];
  end

`ifdef ACC_CPU_OVF_TRAP_EN
  logic trap_q, trap_d;
  assign trap = trap_q;
`else
  logic unused_alu_ovf;
  assign unused_alu_ovf = alu_ovf;
  assign trap = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    ac_d        = ac_q;
    ir_d        = ir_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    halted_d    = halted_q;
    fetch_next  = 1'b0;
`ifdef ACC_CPU_OVF_TRAP_EN
    trap_d      = trap_q;
`endif
    case (state_q)
      S_FETCH: begin
        // Only after reset does FETCH start without a request already raised.
        if (!mem_req_q) begin
          mem_req_d  = 1'b1;
          mem_we_d   = 1'b0;
          mem_addr_d = pc_q;
        end else if (bus.mem_ready) begin
          ir_d      = bus.mem_rdata;
          pc_d      = pc_q + ADDR_W'(1);
          mem_req_d = 1'b0;
          state_d   = S_DECODE;
        end
      end
      S_DECODE: begin
        case (opcode)
          OP_JMP: begin
            pc_d       = operand;
            fetch_next = 1'b1;
          end
          OP_JZ: begin
            if (alu_zero) pc_d = operand;
            fetch_next = 1'b1;
          end
          OP_LD, OP_ADD, OP_SUB, OP_AND: begin
            state_d    = S_READ;
            mem_req_d  = 1'b1;
            mem_we_d   = 1'b0;
            mem_addr_d = operand;
          end
          OP_ST: begin
            state_d     = S_WRITE;
            mem_req_d   = 1'b1;
            mem_we_d    = 1'b1;
            mem_addr_d  = operand;
            mem_wdata_d = ac_q;
          end
          default: begin
            if (operand[0] == SYS_HALT) begin
              state_d  = S_HALT;
              halted_d = 1'b1;
            end else begin
              state_d     = S_OUT;
              out_valid_d = 1'b1;
              out_data_d  = ac_q;
            end
          end
        endcase
      end
      S_READ: begin
        if (bus.mem_ready) begin
          mem_req_d = 1'b0;
`ifdef ACC_CPU_OVF_TRAP_EN
          if (alu_ovf) begin
            state_d  = S_HALT;
            halted_d = 1'b1;
            trap_d   = 1'b1;
          end else begin
            ac_d       = alu_y;
            fetch_next = 1'b1;
          end
`else
          ac_d       = alu_y;
          fetch_next = 1'b1;
`endif
        end
      end
      S_WRITE: begin
        if (bus.mem_ready) fetch_next = 1'b1;
      end
      S_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          fetch_next  = 1'b1;
        end
      end
      default: ;
    endcase
    // Raise the next instruction fetch in the same edge that finishes the current one.
    if (fetch_next) begin
      state_d    = S_FETCH;
      mem_req_d  = 1'b1;
      mem_we_d   = 1'b0;
      mem_addr_d = pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      ac_q        <= '0;
      ir_q        <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      halted_q    <= 1'b0;
`ifdef ACC_CPU_OVF_TRAP_EN
      trap_q      <= 1'b0;
`endif
    end else if (ce) begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      ac_q        <= ac_d;
      ir_q        <= ir_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      halted_q    <= halted_d;
`ifdef ACC_CPU_OVF_TRAP_EN
      trap_q      <= trap_d;
`endif
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign halted        = halted_q;
  assign pc_dbg        = pc_q;

endmodule

// File: tb/tb_acc_cpu_core.sv
// Scoreboard bench for acc_cpu_core: a memory/consumer model with programmable
// wait states; memory writes and output words are checked against expected events.
module tb_acc_cpu_core;

  localparam int DW = 18;
  localparam int AW = 13;

  localparam logic [2:0] LD = 3'd0, ST = 3'd1, ADD = 3'd2, SUB = 3'd3;
  localparam logic [2:0] ANDI = 3'd4, JMP = 3'd5, JZ = 3'd6, SYS = 3'd7;

  typedef struct packed {
    logic          is_out;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ev_t;

  logic          clk = 1'b0;
  logic          reset;
  logic          ce;
  logic          halted, trap;
  logic [AW-1:0] pc_dbg;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  ev_t           sb[$];
  int            n_vec = 0;
  int            n_err = 0;
  int            mem_wait = 0, out_wait = 0, mcnt = 0, ocnt = 0;
  bit            ce_toggle = 1'b0;
  bit            held = 1'b0, oheld = 1'b0;
  logic [AW-1:0] h_addr;
  logic          h_we;
  logic [DW-1:0] h_wdata, h_odata;

  acc_cpu_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  acc_cpu_core #(.DATA_W(DW), .ADDR_W(AW), .RESET_PC(13'd0)) dut (
    .clk    (clk),
    .reset  (reset),
    .ce     (ce),
    .bus    (bus),
    .halted (halted),
    .trap   (trap),
    .pc_dbg (pc_dbg)
  );

  always #5 clk = ~clk;

  assign bus.mem_rdata = mem[bus.mem_addr];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] enc(input logic [2:0] op, input int opd);
    logic [31:0] v;
    v = opd;
    return {op, 2'b00, v[AW-1:0]};
  endfunction

  task automatic push_ev(input bit is_out, input int addr, input int data);
    ev_t e;
    e.is_out = is_out;
    e.addr   = AW'(addr);
    e.data   = DW'(data);
    sb.push_back(e);
  endtask

  task automatic pop_cmp(input bit is_out, input logic [AW-1:0] addr, input logic [DW-1:0] data);
    ev_t e;
    check("sb_has_entry", 32'(sb.size() > 0), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      check("ev_kind", 32'(is_out), 32'(e.is_out));
      if (!is_out) check("wr_addr", 32'(addr), 32'(e.addr));
      check(is_out ? "out_data" : "wr_data", 32'(data), 32'(e.data));
    end
  endtask

  // Memory and consumer responder; decides ready for the coming edge and logs completions.
  always begin
    @(negedge clk);
    ce = ce_toggle ? ~ce : 1'b1;
    #1;
    if (reset) begin
      mcnt = 0; ocnt = 0; held = 1'b0; oheld = 1'b0;
      bus.mem_ready = 1'b0;
      bus.out_ready = 1'b0;
    end else begin
      if (bus.mem_req) begin
        if (held) begin
          check("req_addr_stable", 32'(bus.mem_addr), 32'(h_addr));
          check("req_we_stable", 32'(bus.mem_we), 32'(h_we));
          if (bus.mem_we) check("req_wdata_stable", 32'(bus.mem_wdata), 32'(h_wdata));
        end
        bus.mem_ready = (mcnt >= mem_wait);
        if (ce && bus.mem_ready) begin
          if (bus.mem_we) begin
            mem[bus.mem_addr] = bus.mem_wdata;
            $display("mem write addr=%0d data=%h", bus.mem_addr, bus.mem_wdata);
            pop_cmp(1'b0, bus.mem_addr, bus.mem_wdata);
          end
          mcnt = 0;
          held = 1'b0;
        end else begin
          if (ce) mcnt++;
          held = 1'b1; h_addr = bus.mem_addr; h_we = bus.mem_we; h_wdata = bus.mem_wdata;
        end
      end else begin
        bus.mem_ready = 1'b0;
        held = 1'b0;
      end
      if (bus.out_valid) begin
        if (oheld) check("out_data_stable", 32'(bus.out_data), 32'(h_odata));
        bus.out_ready = (ocnt >= out_wait);
        if (ce && bus.out_ready) begin
          $display("out word data=%h", bus.out_data);
          pop_cmp(1'b1, '0, bus.out_data);
          ocnt = 0;
          oheld = 1'b0;
        end else begin
          if (ce) ocnt++;
          oheld = 1'b1; h_odata = bus.out_data;
        end
      end else begin
        bus.out_ready = 1'b0;
        oheld = 1'b0;
      end
    end
  end

  task automatic start_prog();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < (1 << AW); i++) mem[i] = '0;
    sb.delete();
  endtask

  task automatic wait_halt(input int limit, output int cycles);
    cycles = 0;
    while (!halted && cycles < limit) begin
      @(negedge clk);
      cycles++;
    end
    check("halted", 32'(halted), 32'd1);
  endtask

  task automatic load_basic();
    mem[0] = enc(LD, 10); mem[1] = enc(ADD, 11); mem[2] = enc(ST, 12); mem[3] = enc(SYS, 1);
    mem[10] = 18'd5; mem[11] = 18'd7;
    push_ev(1'b0, 12, 12);
  endtask

  initial begin
    int cyc;
    reset = 1'b1; ce = 1'b1;
    bus.mem_ready = 1'b0; bus.out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("rst_mem_wdata", 32'(bus.mem_wdata), 32'd0);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_data", 32'(bus.out_data), 32'd0);
    check("rst_halted", 32'(halted), 32'd0);
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_pc", 32'(pc_dbg), 32'd0);

    // Zero-wait: one request-raise cycle, then LD 3 + ADD 3 + ST 3 + HALT 2.
    start_prog(); load_basic(); mem_wait = 0;
    reset = 1'b0;
    wait_halt(200, cyc);
    check("t1_halt_cycle", 32'(cyc), 32'd12);
    check("t1_pc", 32'(pc_dbg), 32'd4);
    check("t1_trap", 32'(trap), 32'd0);
    check("t1_mem12", 32'(mem[12]), 32'd12);
    check("t1_sb_empty", 32'(sb.size()), 32'd0);

    // Three wait states on each of the seven transfers.
    start_prog(); load_basic(); mem_wait = 3;
    reset = 1'b0;
    wait_halt(400, cyc);
    check("t2_halt_cycle", 32'(cyc), 32'd33);
    check("t2_mem12", 32'(mem[12]), 32'd12);
    check("t2_sb_empty", 32'(sb.size()), 32'd0);

    // JZ taken with AC=0, falls through with AC=1; then JMP.
    start_prog(); mem_wait = 0; out_wait = 0;
    mem[0] = enc(JZ, 20); mem[1] = enc(SYS, 1);
    mem[20] = enc(LD, 30); mem[21] = enc(JZ, 40); mem[22] = enc(SYS, 0);
    mem[23] = enc(JMP, 60); mem[24] = enc(SYS, 1);
    mem[40] = enc(ST, 50); mem[41] = enc(SYS, 1); mem[60] = enc(SYS, 1);
    mem[30] = 18'd1;
    push_ev(1'b1, 0, 1);
    reset = 1'b0;
    wait_halt(300, cyc);
    check("t3_pc", 32'(pc_dbg), 32'd61);
    check("t3_sb_empty", 32'(sb.size()), 32'd0);

    // OUT held by a consumer that stalls four cycles.
    start_prog(); mem_wait = 0; out_wait = 4;
    mem[0] = enc(LD, 10); mem[1] = enc(SYS, 0); mem[2] = enc(LD, 11);
    mem[3] = enc(ST, 12); mem[4] = enc(SYS, 1);
    mem[10] = 18'h2A; mem[11] = 18'd5;
    push_ev(1'b1, 0, 'h2A); push_ev(1'b0, 12, 5);
    reset = 1'b0;
    wait_halt(300, cyc);
    check("t4_halt_cycle", 32'(cyc), 32'd19);
    check("t4_pc", 32'(pc_dbg), 32'd5);
    check("t4_sb_empty", 32'(sb.size()), 32'd0);
    out_wait = 0;

    // Signed overflow 0x1FFFF + 1.
    start_prog();
    mem[0] = enc(LD, 10); mem[1] = enc(ADD, 11); mem[2] = enc(ST, 12); mem[3] = enc(SYS, 1);
    mem[10] = 18'h1FFFF; mem[11] = 18'd1;
`ifdef ACC_CPU_OVF_TRAP_EN
    reset = 1'b0;
    wait_halt(300, cyc);
    check("t5_trap", 32'(trap), 32'd1);
    check("t5_pc", 32'(pc_dbg), 32'd2);
`else
    push_ev(1'b0, 12, 'h20000);
    reset = 1'b0;
    wait_halt(300, cyc);
    check("t5_trap", 32'(trap), 32'd0);
    check("t5_pc", 32'(pc_dbg), 32'd4);
`endif
    check("t5_sb_empty", 32'(sb.size()), 32'd0);

    // SUB, AND, OUT and a borrow that wraps without signed overflow.
    start_prog();
    mem[0] = enc(LD, 10); mem[1] = enc(SUB, 11); mem[2] = enc(ST, 12);
    mem[3] = enc(ANDI, 13); mem[4] = enc(ST, 14); mem[5] = enc(SYS, 0);
    mem[6] = enc(LD, 15); mem[7] = enc(SUB, 16); mem[8] = enc(ST, 17); mem[9] = enc(SYS, 1);
    mem[10] = 18'd100; mem[11] = 18'd30; mem[13] = 18'h0F; mem[15] = 18'd0; mem[16] = 18'd1;
    push_ev(1'b0, 12, 70); push_ev(1'b0, 14, 6); push_ev(1'b1, 0, 6); push_ev(1'b0, 17, 'h3FFFF);
    reset = 1'b0;
    wait_halt(400, cyc);
    check("t6_pc", 32'(pc_dbg), 32'd10);
    check("t6_trap", 32'(trap), 32'd0);
    check("t6_sb_empty", 32'(sb.size()), 32'd0);

    // PC at the top address wraps to zero.
    start_prog();
    mem[0] = enc(JMP, (1 << AW) - 1); mem[(1 << AW) - 1] = enc(SYS, 1);
    reset = 1'b0;
    wait_halt(100, cyc);
    check("t7_pc_wrap", 32'(pc_dbg), 32'd0);

    // Reset in the middle of a stalled READ while ce toggles.
    start_prog(); mem_wait = 3; ce_toggle = 1'b1;
    mem[0] = enc(LD, 10); mem[1] = enc(ST, 11); mem[2] = enc(SYS, 1);
    mem[10] = 18'h155;
    push_ev(1'b0, 11, 'h155);
    reset = 1'b0;
    cyc = 0;
    while (!(bus.mem_req && bus.mem_addr == 13'd10) && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("t8_reached_read", 32'(bus.mem_addr), 32'd10);
    reset = 1'b1;
    @(negedge clk);
    check("t8_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("t8_rst_mem_addr", 32'(bus.mem_addr), 32'd0);
    check("t8_rst_mem_we", 32'(bus.mem_we), 32'd0);
    check("t8_rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("t8_rst_halted", 32'(halted), 32'd0);
    check("t8_rst_pc", 32'(pc_dbg), 32'd0);
    ce_toggle = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check("t8_refetch_req", 32'(bus.mem_req), 32'd1);
    check("t8_refetch_addr", 32'(bus.mem_addr), 32'd0);
    wait_halt(400, cyc);
    check("t8_mem11", 32'(mem[11]), 32'h155);
    check("t8_sb_empty", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
